// File: rtl/qrs_peak_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qrs_peak_detector: adaptive-threshold QRS detector on the MPavg stream.
// Rev 1.0
// ----------------------------------------------------------------------------
module qrs_peak_detector #(
  parameter int unsigned W         = 32,
  parameter int unsigned CW        = 16,
  parameter int unsigned LEARN_LEN = 256,
  parameter int unsigned REFRACT   = 50,
  parameter int unsigned MAX_WIDTH = 40,
  parameter int unsigned RR_MAX    = 500
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  mpavg,
  input  logic          mpavg_valid,
  output logic          qrs_valid,
  output logic [W-1:0]  peak_value,
  output logic [CW-1:0] rr_interval,
  output logic [W-1:0]  threshold,
  output logic          learning
);

  typedef enum logic [1:0] {
    S_LEARN   = 2'd0,
    S_SEARCH  = 2'd1,
    S_PEAK    = 2'd2,
    S_REFRACT = 2'd3
  } state_t;

  localparam logic [CW-1:0] LEARN_LAST   = CW'(LEARN_LEN - 1);
  localparam logic [CW-1:0] REFRACT_LAST = CW'(REFRACT - 1);
  localparam logic [CW-1:0] RR_LAST      = CW'(RR_MAX - 1);
  localparam logic [CW-1:0] WIDTH_LIMIT  = CW'(MAX_WIDTH);

  state_t        state_q, state_d;
  // One counter serves learn count, miss count, excursion width and refractory
  // count; each belongs to exactly one state and is cleared on every transition.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  pk_q, pk_d;
  logic [W-1:0]  spk_q, spk_d;
  logic [W-1:0]  thr_q, thr_d;
  logic [CW-1:0] since_q, since_d;
  logic          first_q, first_d;
  logic          qrs_valid_q, qrs_valid_d;
  logic [W-1:0]  peak_value_q, peak_value_d;
  logic [CW-1:0] rr_q, rr_d;
  logic          learning_q, learning_d;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] since_inc;
  logic [W-1:0]  max_v;
  logic [W-1:0]  spk_new;

  always_comb begin
    cnt_inc   = cnt_q + 1'b1;
    since_inc = (since_q == {CW{1'b1}}) ? since_q : since_q + 1'b1;
    max_v     = (mpavg > pk_q) ? mpavg : pk_q;
    spk_new   = spk_q - (spk_q >> 3) + (pk_q >> 3);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pk_d         = pk_q;
    spk_d        = spk_q;
    thr_d        = thr_q;
    since_d      = since_q;
    first_d      = first_q;
    qrs_valid_d  = 1'b0;
    peak_value_d = peak_value_q;
    rr_d         = rr_q;

    if (mpavg_valid) begin
      since_d = since_inc;
      case (state_q)
        S_LEARN: begin
          pk_d = max_v;
          if (cnt_q == LEARN_LAST) begin
            spk_d   = max_v;
            thr_d   = max_v >> 1;
            state_d = S_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_SEARCH: begin
          if (mpavg > thr_q) begin
            state_d = S_PEAK;
            pk_d    = mpavg;
            cnt_d   = CW'(1);
          end else if (cnt_q == RR_LAST) begin
            thr_d = thr_q >> 1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_PEAK: begin
          // The exit sample never contributes to the peak, forced or not.
          if ((mpavg <= thr_q) || (cnt_inc == WIDTH_LIMIT)) begin
            qrs_valid_d  = 1'b1;
            peak_value_d = pk_q;
            rr_d         = first_q ? '0 : since_inc;
            since_d      = '0;
            first_d      = 1'b0;
            spk_d        = spk_new;
            thr_d        = spk_new >> 1;
            state_d      = S_REFRACT;
            cnt_d        = '0;
          end else begin
            pk_d  = max_v;
            cnt_d = cnt_inc;
          end
        end
        S_REFRACT: begin
          if (cnt_q == REFRACT_LAST) begin
            state_d = S_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_LEARN;
          cnt_d   = '0;
          pk_d    = '0;
        end
      endcase
    end

    learning_d = (state_d == S_LEARN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LEARN;
      cnt_q        <= '0;
      pk_q         <= '0;
      spk_q        <= '0;
      thr_q        <= '0;
      since_q      <= '0;
      first_q      <= 1'b1;
      qrs_valid_q  <= 1'b0;
      peak_value_q <= '0;
      rr_q         <= '0;
      learning_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pk_q         <= pk_d;
      spk_q        <= spk_d;
      thr_q        <= thr_d;
      since_q      <= since_d;
      first_q      <= first_d;
      qrs_valid_q  <= qrs_valid_d;
      peak_value_q <= peak_value_d;
      rr_q         <= rr_d;
      learning_q   <= learning_d;
    end
  end

  assign qrs_valid   = qrs_valid_q;
  assign peak_value  = peak_value_q;
  assign rr_interval = rr_q;
  assign threshold   = thr_q;
  assign learning    = learning_q;

endmodule
`default_nettype wire

// File: tb/tb_qrs_peak_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_qrs_peak_detector: directed and randomized checks against a sample model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_qrs_peak_detector;

  localparam int W         = 32;
  localparam int CW        = 16;
  localparam int LEARN_LEN = 8;
  localparam int REFRACT   = 4;
  localparam int MAX_WIDTH = 6;
  localparam int RR_MAX    = 10;

  localparam int P_LEARN   = 0;
  localparam int P_SEARCH  = 1;
  localparam int P_PEAK    = 2;
  localparam int P_REFRACT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  mpavg = '0;
  logic          mpavg_valid = 1'b0;
  logic          qrs_valid;
  logic [W-1:0]  peak_value;
  logic [CW-1:0] rr_interval;
  logic [W-1:0]  threshold;
  logic          learning;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: one phase per detector activity, plain counters.
  int          m_phase;
  int          m_learn_n, m_miss, m_width, m_ref, m_since;
  logic [31:0] m_max, m_spk, m_thr, m_pk;
  bit          m_first;
  logic        m_qv, m_learn;
  logic [31:0] m_peak;
  logic [15:0] m_rr;

  qrs_peak_detector #(
    .W(W), .CW(CW), .LEARN_LEN(LEARN_LEN), .REFRACT(REFRACT),
    .MAX_WIDTH(MAX_WIDTH), .RR_MAX(RR_MAX)
  ) dut (
    .clk(clk), .rst(rst), .mpavg(mpavg), .mpavg_valid(mpavg_valid),
    .qrs_valid(qrs_valid), .peak_value(peak_value), .rr_interval(rr_interval),
    .threshold(threshold), .learning(learning)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic [31:0] s, input logic v);
    if (r) begin
      m_phase = P_LEARN; m_learn_n = 0; m_miss = 0; m_width = 0; m_ref = 0;
      m_since = 0; m_max = 0; m_spk = 0; m_thr = 0; m_pk = 0; m_first = 1;
      m_qv = 0; m_learn = 1; m_peak = 0; m_rr = 0;
      return;
    end
    m_qv = 0;
    if (!v) return;
    if (m_since < 65535) m_since++;
    case (m_phase)
      P_LEARN: begin
        if (s > m_max) m_max = s;
        m_learn_n++;
        if (m_learn_n == LEARN_LEN) begin
          m_spk = m_max; m_thr = m_spk >> 1; m_phase = P_SEARCH; m_miss = 0; m_learn = 0;
        end
      end
      P_SEARCH: begin
        if (s > m_thr) begin
          m_phase = P_PEAK; m_pk = s; m_width = 1;
        end else begin
          m_miss++;
          if (m_miss == RR_MAX) begin m_thr = m_thr >> 1; m_miss = 0; end
        end
      end
      P_PEAK: begin
        if (s <= m_thr || m_width + 1 == MAX_WIDTH) begin
          m_qv = 1; m_peak = m_pk; m_rr = m_first ? 16'd0 : 16'(m_since);
          m_since = 0; m_first = 0;
          m_spk = m_spk - (m_spk >> 3) + (m_pk >> 3);
          m_thr = m_spk >> 1; m_phase = P_REFRACT; m_ref = 0;
        end else begin
          if (s > m_pk) m_pk = s;
          m_width++;
        end
      end
      default: begin
        m_ref++;
        if (m_ref == REFRACT) begin m_phase = P_SEARCH; m_miss = 0; end
      end
    endcase
  endtask

  task automatic step(input logic [31:0] s, input logic v, input logic r);
    @(negedge clk);
    rst = r; mpavg = s; mpavg_valid = v;
    @(posedge clk);
    model_step(r, s, v);
    #1;
  endtask

  task automatic learn_const(input logic [31:0] s);
    for (int i = 0; i < LEARN_LEN; i++) step(s, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    step(32'd1234, 1'b1, 1'b1);
    step(32'd99, 1'b1, 1'b1);
    n_vec++;
    if (qrs_valid !== 1'b0 || peak_value !== 32'd0 || rr_interval !== 16'd0 ||
        threshold !== 32'd0 || learning !== 1'b1) begin
      n_err++;
      $display("FAIL reset: qrs=%0b peak=%0d rr=%0d thr=%0d learn=%0b, want 0 0 0 0 1",
               qrs_valid, peak_value, rr_interval, threshold, learning);
    end
  endtask

  task automatic test_learn;
    logic [31:0] vals [8] = '{32'd100, 32'd400, 32'd1000, 32'd30, 32'd999, 32'd0, 32'd700, 32'd5};
    step(32'd0, 1'b0, 1'b1);
    for (int i = 0; i < LEARN_LEN; i++) begin
      step(vals[i], 1'b1, 1'b0);
      if (i < LEARN_LEN - 1) begin
        n_vec++;
        if (qrs_valid !== 1'b0 || learning !== 1'b1 || threshold !== 32'd0) begin
          n_err++;
          $display("FAIL learn_phase[%0d]: qrs=%0b learn=%0b thr=%0d, want 0 1 0",
                   i, qrs_valid, learning, threshold);
        end
      end
    end
    n_vec++;
    if (threshold !== 32'd500 || learning !== 1'b0 || qrs_valid !== 1'b0) begin
      n_err++;
      $display("FAIL learn_done: thr=%0d learn=%0b qrs=%0b, want 500 0 0",
               threshold, learning, qrs_valid);
    end
  endtask

  task automatic test_detect;
    step(32'd600, 1'b1, 1'b0);
    step(32'd900, 1'b1, 1'b0);
    step(32'd700, 1'b1, 1'b0);
    n_vec++;
    if (qrs_valid !== 1'b0) begin
      n_err++;
      $display("FAIL detect_early: qrs=%0b want 0", qrs_valid);
    end
    step(32'd200, 1'b1, 1'b0);
    n_vec++;
    if (qrs_valid !== 1'b1 || peak_value !== 32'd900 || rr_interval !== 16'd0 ||
        threshold !== 32'd493) begin
      n_err++;
      $display("FAIL detect_first: qrs=%0b peak=%0d rr=%0d thr=%0d, want 1 900 0 493",
               qrs_valid, peak_value, rr_interval, threshold);
    end
  endtask

  task automatic test_refract;
    for (int i = 0; i < REFRACT; i++) begin
      step(32'd2000, 1'b1, 1'b0);
      n_vec++;
      if (qrs_valid !== 1'b0 || peak_value !== 32'd900) begin
        n_err++;
        $display("FAIL refract[%0d]: qrs=%0b peak=%0d, want 0 900", i, qrs_valid, peak_value);
      end
    end
    step(32'd800, 1'b1, 1'b0);
    step(32'd100, 1'b1, 1'b0);
    n_vec++;
    if (qrs_valid !== 1'b1 || peak_value !== 32'd800 || rr_interval !== 16'd6 ||
        threshold !== 32'd482) begin
      n_err++;
      $display("FAIL detect_second: qrs=%0b peak=%0d rr=%0d thr=%0d, want 1 800 6 482",
               qrs_valid, peak_value, rr_interval, threshold);
    end
    step(32'd0, 1'b1, 1'b0);
    n_vec++;
    if (qrs_valid !== 1'b0 || peak_value !== 32'd800 || rr_interval !== 16'd6) begin
      n_err++;
      $display("FAIL hold_outputs: qrs=%0b peak=%0d rr=%0d, want 0 800 6",
               qrs_valid, peak_value, rr_interval);
    end
  endtask

  task automatic test_forced_emit;
    step(32'd0, 1'b0, 1'b1);
    learn_const(32'd1000);
    for (int i = 0; i < MAX_WIDTH; i++) begin
      step(32'd600, 1'b1, 1'b0);
      if (i < MAX_WIDTH - 1) begin
        n_vec++;
        if (qrs_valid !== 1'b0) begin
          n_err++;
          $display("FAIL forced_early[%0d]: qrs=%0b want 0", i, qrs_valid);
        end
      end
    end
    n_vec++;
    if (qrs_valid !== 1'b1 || peak_value !== 32'd600 || rr_interval !== 16'd0) begin
      n_err++;
      $display("FAIL forced_emit: qrs=%0b peak=%0d rr=%0d, want 1 600 0",
               qrs_valid, peak_value, rr_interval);
    end
  endtask

  task automatic test_miss_decay;
    step(32'd0, 1'b0, 1'b1);
    learn_const(32'd1000);
    for (int i = 0; i < RR_MAX - 1; i++) step(32'd0, 1'b1, 1'b0);
    n_vec++;
    if (threshold !== 32'd500) begin
      n_err++;
      $display("FAIL miss_before: thr=%0d want 500", threshold);
    end
    step(32'd0, 1'b1, 1'b0);
    n_vec++;
    if (threshold !== 32'd250) begin
      n_err++;
      $display("FAIL miss_first_halve: thr=%0d want 250", threshold);
    end
    for (int i = 0; i < RR_MAX; i++) step(32'd0, 1'b1, 1'b0);
    n_vec++;
    if (threshold !== 32'd125 || qrs_valid !== 1'b0) begin
      n_err++;
      $display("FAIL miss_second_halve: thr=%0d qrs=%0b want 125 0", threshold, qrs_valid);
    end
  endtask

  task automatic test_reset_mid_peak;
    step(32'd0, 1'b0, 1'b1);
    learn_const(32'd1000);
    step(32'd600, 1'b1, 1'b0);
    step(32'd900, 1'b1, 1'b0);
    step(32'd100, 1'b1, 1'b1);
    n_vec++;
    if (qrs_valid !== 1'b0 || peak_value !== 32'd0 || rr_interval !== 16'd0 ||
        threshold !== 32'd0 || learning !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_peak: qrs=%0b peak=%0d rr=%0d thr=%0d learn=%0b, want 0 0 0 0 1",
               qrs_valid, peak_value, rr_interval, threshold, learning);
    end
  endtask

  task automatic test_gaps;
    logic [31:0] seq [4] = '{32'd600, 32'd900, 32'd700, 32'd200};
    step(32'd0, 1'b0, 1'b1);
    for (int i = 0; i < LEARN_LEN; i++) begin
      step(32'd1000, 1'b1, 1'b0);
      step($urandom, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 2; g++) begin
        step($urandom, 1'b0, 1'b0);
        n_vec++;
        if (qrs_valid !== 1'b0 || threshold !== 32'd500) begin
          n_err++;
          $display("FAIL gap_idle[%0d]: qrs=%0b thr=%0d, want 0 500", i, qrs_valid, threshold);
        end
      end
      step(seq[i], 1'b1, 1'b0);
    end
    n_vec++;
    if (qrs_valid !== 1'b1 || peak_value !== 32'd900 || rr_interval !== 16'd0 ||
        threshold !== 32'd493) begin
      n_err++;
      $display("FAIL gap_detect: qrs=%0b peak=%0d rr=%0d thr=%0d, want 1 900 0 493",
               qrs_valid, peak_value, rr_interval, threshold);
    end
  endtask

  task automatic test_random;
    logic [31:0] s;
    logic        v, r;
    int          sel;
    step(32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 799) == 0);
      sel = $urandom_range(0, 19);
      if (sel < 10)      s = $urandom_range(0, 600);
      else if (sel < 19) s = $urandom_range(400, 3000);
      else               s = $urandom;
      step(s, v, r);
      n_vec++;
      if (qrs_valid !== m_qv || peak_value !== m_peak || rr_interval !== m_rr ||
          threshold !== m_thr || learning !== m_learn) begin
        n_err++;
        $display("FAIL random[%0d]: got qrs=%0b peak=%0d rr=%0d thr=%0d learn=%0b, want %0b %0d %0d %0d %0b",
                 i, qrs_valid, peak_value, rr_interval, threshold, learning,
                 m_qv, m_peak, m_rr, m_thr, m_learn);
      end
    end
  endtask

  initial begin
    model_step(1'b1, 32'd0, 1'b0);
    test_reset;
    test_learn;
    test_detect;
    test_refract;
    test_forced_emit;
    test_miss_decay;
    test_reset_mid_peak;
    test_gaps;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
